// File: rtl/stack_host.sv
// stack_host: request/response front end for an external 4-bit, 5-deep stack.
// A user request is accepted in IDLE. It is then issued for one cycle on the
// COMMAND/INDEX/IO_DATA stack bus, and the result is held in RESP until the
// user accepts it. The host also keeps a shadow occupancy count of the stack.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset (shared with stack)
//   req_valid/req_ready   request handshake; req_cmd 00 NOP 01 POP 10 PUSH 11 GET
//   req_index, req_data   GET depth below top, PUSH payload
//   rsp_valid/rsp_ready   response handshake; rsp_data read/echo data, rsp_err reject
//   COMMAND, INDEX        stack command bus (idle value 00 / 000)
//   IO_DATA               bidirectional stack data bus
//   count                 shadow stack occupancy
//
// Build option: define STACK_HOST_GUARD_EN to reject a PUSH when the stack is
// full, a POP when it is empty, and a GET beyond the occupancy. These rejected
// requests answer with rsp_err=1 and never reach the bus. Without the option,
// every request is forwarded and count wraps modulo DEPTH.
module stack_host #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [2:0]        req_index,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [1:0]        COMMAND,
  output logic [2:0]        INDEX,
  inout  wire  [DATA_W-1:0] IO_DATA,
  output logic [2:0]        count
);

  localparam int unsigned CMD_W = 2;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 3;

  localparam logic [CMD_W-1:0] CMD_NOP  = 2'b00;
  localparam logic [CMD_W-1:0] CMD_POP  = 2'b01;
  localparam logic [CMD_W-1:0] CMD_PUSH = 2'b10;
  localparam logic [CMD_W-1:0] CMD_GET  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                drive, drive_d;
  logic                req_ready_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic                rsp_err_d;
  logic [CMD_W-1:0]    command_d;
  logic [IDX_W-1:0]    index_d;
  logic [CNT_W-1:0]    count_d;
  logic [CNT_W-1:0]    count_inc;
  logic [CNT_W-1:0]    count_dec;
  logic                reject;

  // Bus data is driven only during the ISSUE cycle of a PUSH.
  assign IO_DATA = drive ? data_q : {DATA_W{1'bz}};

`ifdef STACK_HOST_GUARD_EN
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Requests that would overflow, underflow or read past the occupancy.
  assign reject = ((req_cmd == CMD_PUSH) && (count == CNT_FULL)) ||
                  ((req_cmd == CMD_POP)  && (count == '0)) ||
                  ((req_cmd == CMD_GET)  && (req_index >= count));
  assign count_inc = count + CNT_W'(1);
  assign count_dec = count - CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEPTH - 1);

  // Unguarded: forward everything and keep count in 0..DEPTH-1.
  assign reject    = 1'b0;
  assign count_inc = (count == CNT_TOP) ? '0 : count + CNT_W'(1);
  assign count_dec = (count == '0) ? CNT_TOP : count - CNT_W'(1);
`endif

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      data_q    <= '0;
      drive     <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      COMMAND   <= CMD_NOP;
      INDEX     <= '0;
      count     <= '0;
    end else begin
      state     <= state_d;
      data_q    <= data_d;
      drive     <= drive_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      COMMAND   <= command_d;
      INDEX     <= index_d;
      count     <= count_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d     = state;
    data_d      = data_q;
    drive_d     = 1'b0;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    command_d   = CMD_NOP;
    index_d     = '0;
    count_d     = count;

    case (state)
      IDLE: begin
        // req_ready stays low for the first IDLE cycle after reset.
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          data_d      = req_data;
          if ((req_cmd == CMD_NOP) || reject) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = reject;
          end else begin
            state_d   = ISSUE;
            command_d = req_cmd;
            index_d   = req_index;
            drive_d   = (req_cmd == CMD_PUSH);
          end
        end
      end

      ISSUE: begin
        // COMMAND still holds the issued command during this cycle.
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        case (COMMAND)
          CMD_PUSH: begin
            rsp_data_d = data_q;
            count_d    = count_inc;
          end
          CMD_POP: begin
            rsp_data_d = IO_DATA;
            count_d    = count_dec;
          end
          CMD_GET: rsp_data_d = IO_DATA;
          default: rsp_data_d = '0;
        endcase
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_host.sv
// tb_stack_host: directed bench for stack_host with a small behavioural stack
// attached to the COMMAND/INDEX/IO_DATA bus. The bus is pulled high, so an
// undriven IO_DATA reads 4'hF.
module tb_stack_host;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] PUSH = 2'b10;
  localparam logic [1:0] GET  = 2'b11;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [2:0] req_index;
  logic [3:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [1:0] COMMAND;
  logic [2:0] INDEX;
  logic [2:0] count;
  tri1  [3:0] io_data;

  int n_checks = 0;
  int n_pass   = 0;

  stack_host dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_index (req_index),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .COMMAND   (COMMAND),
    .INDEX     (INDEX),
    .IO_DATA   (io_data),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  // Behavioural stack: answers POP/GET on the bus, stores PUSH data.
  int         sp;
  int         gi;
  logic [3:0] mem [0:7];
  logic       stk_oe;
  logic [3:0] stk_out;

  always_comb begin
    stk_oe  = (COMMAND == POP) || (COMMAND == GET);
    stk_out = 4'h0;
    gi      = 0;
    if (COMMAND == POP) begin
      if (sp > 0) stk_out = mem[3'(sp - 1)];
    end else if (COMMAND == GET) begin
      gi = sp - 1 - int'(INDEX);
      if (gi >= 0) stk_out = mem[3'(gi)];
    end
  end

  assign io_data = stk_oe ? stk_out : 4'bzzzz;

  always @(posedge CLK) begin
    if (RESET) begin
      sp <= 0;
    end else if ((COMMAND == PUSH) && (sp < 5)) begin
      mem[3'(sp)] <= io_data;
      sp <= sp + 1;
    end else if ((COMMAND == POP) && (sp > 0)) begin
      sp <= sp - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One full request/response transaction; hold = extra RESP cycles with rsp_ready low.
  task automatic do_req(input string tag, input logic [1:0] cmd, input logic [2:0] idx,
                        input logic [3:0] d, input logic fwd, input logic [3:0] exp_data,
                        input logic exp_err, input logic [2:0] exp_cnt, input int hold);
    int waited;
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(posedge CLK); #1;
      waited++;
    end
    check({tag, " ready_in"}, 32'(req_ready), 32'(1'b1));
    req_valid = 1'b1; req_cmd = cmd; req_index = idx; req_data = d;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check({tag, " ready_low"}, 32'(req_ready), 32'(1'b0));
    if (fwd) begin
      check({tag, " issue_cmd"}, 32'(COMMAND), 32'(cmd));
      check({tag, " issue_idx"}, 32'(INDEX), 32'(idx));
      if (cmd == PUSH) check({tag, " issue_bus"}, 32'(io_data), 32'(d));
      @(posedge CLK); #1;
    end else begin
      check({tag, " no_issue"}, 32'(COMMAND), 32'(NOP));
    end
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1'b1));
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, " count"}, 32'(count), 32'(exp_cnt));
    check({tag, " resp_cmd"}, 32'(COMMAND), 32'(NOP));
    for (int i = 0; i < hold; i++) begin
      // A request offered while busy must be ignored.
      req_valid = 1'b1; req_cmd = POP;
      @(posedge CLK); #1;
      check({tag, " hold_valid"}, 32'(rsp_valid), 32'(1'b1));
      check({tag, " hold_data"}, 32'(rsp_data), 32'(exp_data));
      check({tag, " hold_ready"}, 32'(req_ready), 32'(1'b0));
      check({tag, " hold_cmd"}, 32'(COMMAND), 32'(NOP));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    check({tag, " done_valid"}, 32'(rsp_valid), 32'(1'b0));
    check({tag, " done_ready"}, 32'(req_ready), 32'(1'b1));
    check({tag, " idle_bus"}, 32'(io_data), 32'(4'hF));
  endtask

  initial begin
    RESET = 1'b1; req_valid = 1'b0; req_cmd = NOP; req_index = 3'd0;
    req_data = 4'h0; rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst req_ready", 32'(req_ready), 32'(1'b0));
    check("rst rsp_valid", 32'(rsp_valid), 32'(1'b0));
    check("rst rsp_data", 32'(rsp_data), 32'(4'h0));
    check("rst rsp_err", 32'(rsp_err), 32'(1'b0));
    check("rst command", 32'(COMMAND), 32'(NOP));
    check("rst index", 32'(INDEX), 32'(3'd0));
    check("rst count", 32'(count), 32'(3'd0));
    check("rst bus", 32'(io_data), 32'(4'hF));
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("post_rst ready", 32'(req_ready), 32'(1'b1));

    do_req("push3", PUSH, 3'd0, 4'h3, 1'b1, 4'h3, 1'b0, 3'd1, 0);
    do_req("push7", PUSH, 3'd0, 4'h7, 1'b1, 4'h7, 1'b0, 3'd2, 0);
    do_req("pushA", PUSH, 3'd0, 4'hA, 1'b1, 4'hA, 1'b0, 3'd3, 0);
    do_req("get2",  GET,  3'd2, 4'h0, 1'b1, 4'h3, 1'b0, 3'd3, 0);
    do_req("get0",  GET,  3'd0, 4'h0, 1'b1, 4'hA, 1'b0, 3'd3, 0);
    do_req("nop",   NOP,  3'd0, 4'h5, 1'b0, 4'h0, 1'b0, 3'd3, 0);
    do_req("stall", GET,  3'd1, 4'h0, 1'b1, 4'h7, 1'b0, 3'd3, 4);
    do_req("pop1",  POP,  3'd0, 4'h0, 1'b1, 4'hA, 1'b0, 3'd2, 0);
    do_req("pop2",  POP,  3'd0, 4'h0, 1'b1, 4'h7, 1'b0, 3'd1, 0);
    do_req("pop3",  POP,  3'd0, 4'h0, 1'b1, 4'h3, 1'b0, 3'd0, 0);
`ifdef STACK_HOST_GUARD_EN
    do_req("pop_empty", POP, 3'd0, 4'h0, 1'b0, 4'h0, 1'b1, 3'd0, 0);
`else
    do_req("pop_empty", POP, 3'd0, 4'h0, 1'b1, 4'h0, 1'b0, 3'd4, 0);
`endif

    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

`ifdef STACK_HOST_GUARD_EN
    for (int i = 1; i <= 5; i++)
      do_req("fill", PUSH, 3'd0, 4'(i), 1'b1, 4'(i), 1'b0, 3'(i), 0);
    do_req("push_full", PUSH, 3'd0, 4'h6, 1'b0, 4'h0, 1'b1, 3'd5, 0);
    do_req("get4",      GET,  3'd4, 4'h0, 1'b1, 4'h1, 1'b0, 3'd5, 0);
    do_req("get5",      GET,  3'd5, 4'h0, 1'b0, 4'h0, 1'b1, 3'd5, 0);
`else
    for (int i = 1; i <= 5; i++)
      do_req("fill", PUSH, 3'd0, 4'(i), 1'b1, 4'(i), 1'b0, 3'(i % 5), 0);
    do_req("push_wrap", PUSH, 3'd0, 4'h6, 1'b1, 4'h6, 1'b0, 3'd1, 0);
    do_req("get4",      GET,  3'd4, 4'h0, 1'b1, 4'h1, 1'b0, 3'd1, 0);
    do_req("get5",      GET,  3'd5, 4'h0, 1'b1, 4'h0, 1'b0, 3'd1, 0);
`endif

    // Reset during the ISSUE cycle of a PUSH drops the request.
    req_valid = 1'b1; req_cmd = PUSH; req_index = 3'd0; req_data = 4'h9;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("rst_issue cmd", 32'(COMMAND), 32'(PUSH));
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("rst_issue command", 32'(COMMAND), 32'(NOP));
    check("rst_issue count", 32'(count), 32'(3'd0));
    check("rst_issue rsp_valid", 32'(rsp_valid), 32'(1'b0));
    check("rst_issue req_ready", 32'(req_ready), 32'(1'b0));
    check("rst_issue bus", 32'(io_data), 32'(4'hF));
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("rst_issue after valid", 32'(rsp_valid), 32'(1'b0));
    check("rst_issue after ready", 32'(req_ready), 32'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
